// File: rtl/rv32_types_pkg.sv
// Shared RV32 core types: register ids, data words, writeback arbiter
// state encoding and starvation counter width.
package rv32_types;

   typedef logic [4:0]  rv_reg_id_t;
   typedef logic [31:0] rv32_word;

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      FORCE
   } wb_arb_state_t;

   localparam int WB_ARB_STARVE_W = 4;

endpackage

// File: rtl/rv32_busy_scoreboard.sv
// Per-register outstanding-write mask; a set beats a clear on the same
// bit in the same cycle, and x0 is never marked busy.
module rv32_busy_scoreboard
   import rv32_types::*;
(
   input  logic       clk,
   input  logic       resetn,
   input  logic       set_en,
   input  rv_reg_id_t set_rd,
   input  logic       clr_en,
   input  rv_reg_id_t clr_rd,
   output rv32_word   mask
);

   rv32_word set_vec;
   rv32_word clr_vec;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (set_en && set_rd != 5'd0)
         set_vec = 32'd1 << set_rd;
      if (clr_en)
         clr_vec = 32'd1 << clr_rd;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         mask <= '0;
      else
         mask <= (mask & ~clr_vec) | set_vec;
   end

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Register-file write port arbiter: WB stage vs. long-latency unit result.
// RV32_WB_ARB_BYPASS_EN lets an idle-cycle unit result skip the hold buffer.
module rv32_wb_arbiter
   import rv32_types::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        aux_issue_valid,
   input  logic [4:0]  aux_issue_rd,
   input  logic        aux_valid,
   output logic        aux_ready,
   input  logic [4:0]  aux_rd,
   input  logic [31:0] aux_data,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_data,
   output logic        pipe_stall,
   output logic [31:0] busy_mask
);

   typedef logic [WB_ARB_STARVE_W-1:0] starve_t;

   localparam starve_t LAST_DENY = starve_t'(STARVE_LIMIT - 1);

   wb_arb_state_t state;
   wb_arb_state_t state_nxt;
   starve_t       starve_cnt;
   starve_t       starve_nxt;
   rv_reg_id_t    hold_rd;
   rv32_word      hold_data;

   logic       pw;
   logic       load;
   logic       hold_wr;
   logic       byp_wr;
   logic       we_c;
   logic       stall_c;
   logic       ready_c;
   rv_reg_id_t rd_c;
   rv32_word   data_c;

   assign pw = wb_reg_write && (wb_rd != 5'd0);

   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      load       = 1'b0;
      hold_wr    = 1'b0;
      byp_wr     = 1'b0;
      we_c       = 1'b0;
      stall_c    = 1'b0;
      ready_c    = 1'b0;
      rd_c       = wb_rd;
      data_c     = wb_data;
      unique case (state)
         IDLE: begin
            ready_c    = 1'b1;
            we_c       = pw;
            starve_nxt = '0;
`ifdef RV32_WB_ARB_BYPASS_EN
            if (aux_valid && aux_rd != 5'd0 && !pw) begin
               byp_wr = 1'b1;
               we_c   = 1'b1;
               rd_c   = aux_rd;
               data_c = aux_data;
            end else if (aux_valid && aux_rd != 5'd0) begin
               load      = 1'b1;
               state_nxt = PEND;
            end
`else
            if (aux_valid && aux_rd != 5'd0) begin
               load      = 1'b1;
               state_nxt = PEND;
            end
`endif
         end
         PEND: begin
            we_c = 1'b1;
            if (!pw) begin
               hold_wr    = 1'b1;
               rd_c       = hold_rd;
               data_c     = hold_data;
               starve_nxt = '0;
               state_nxt  = IDLE;
            end else begin
               starve_nxt = starve_cnt + 1'b1;
               if (starve_cnt == LAST_DENY)
                  state_nxt = FORCE;
            end
         end
         FORCE: begin
            // WB inputs are held by the stall and retire next cycle
            hold_wr    = 1'b1;
            we_c       = 1'b1;
            rd_c       = hold_rd;
            data_c     = hold_data;
            stall_c    = pw;
            starve_nxt = '0;
            state_nxt  = IDLE;
         end
         default: begin
            state_nxt  = IDLE;
            starve_nxt = '0;
         end
      endcase
   end

   // Outputs are forced quiet while reset is asserted
   assign rf_we      = resetn & we_c;
   assign pipe_stall = resetn & stall_c;
   assign aux_ready  = resetn & ready_c;
   assign rf_rd      = resetn ? rd_c : 5'd0;
   assign rf_data    = resetn ? data_c : 32'd0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         starve_cnt <= '0;
         hold_rd    <= '0;
         hold_data  <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         if (load) begin
            hold_rd   <= aux_rd;
            hold_data <= aux_data;
         end
      end
   end

   rv32_busy_scoreboard u_busy (
      .clk    (clk),
      .resetn (resetn),
      .set_en (aux_issue_valid),
      .set_rd (aux_issue_rd),
      .clr_en (hold_wr | byp_wr),
      .clr_rd (byp_wr ? aux_rd : hold_rd),
      .mask   (busy_mask)
   );

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Directed self-checking bench for rv32_wb_arbiter.
// Bypass expectations follow RV32_WB_ARB_BYPASS_EN.
module tb_rv32_wb_arbiter;

`ifdef RV32_WB_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        resetn;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        aux_issue_valid;
   logic [4:0]  aux_issue_rd;
   logic        aux_valid;
   logic        aux_ready;
   logic [4:0]  aux_rd;
   logic [31:0] aux_data;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data;
   logic        pipe_stall;
   logic [31:0] busy_mask;

   int n_chk;
   int n_fail;

   rv32_wb_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .wb_reg_write    (wb_reg_write),
      .wb_rd           (wb_rd),
      .wb_data         (wb_data),
      .aux_issue_valid (aux_issue_valid),
      .aux_issue_rd    (aux_issue_rd),
      .aux_valid       (aux_valid),
      .aux_ready       (aux_ready),
      .aux_rd          (aux_rd),
      .aux_data        (aux_data),
      .rf_we           (rf_we),
      .rf_rd           (rf_rd),
      .rf_data         (rf_data),
      .pipe_stall      (pipe_stall),
      .busy_mask       (busy_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      wb_reg_write    = 1'b0;
      wb_rd           = 5'd0;
      wb_data         = 32'd0;
      aux_issue_valid = 1'b0;
      aux_issue_rd    = 5'd0;
      aux_valid       = 1'b0;
      aux_rd          = 5'd0;
      aux_data        = 32'd0;
   endtask

   task automatic test_reset();
      quiet();
      resetn       = 1'b0;
      wb_reg_write = 1'b1;
      wb_rd        = 5'd2;
      wb_data      = 32'hFFFF;
      #2;
      n_chk++;
      if (rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_we: got %0b want 0", rf_we);
      end
      n_chk++;
      if (aux_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ready: got %0b want 0", aux_ready);
      end
      tick();
      resetn = 1'b1;
      quiet();
      aux_issue_valid = 1'b1;
      aux_issue_rd    = 5'd5;
      tick();
      aux_issue_valid = 1'b0;
      aux_valid       = 1'b1;
      aux_rd          = 5'd5;
      aux_data        = 32'hAAAA;
      // keep WB busy so the result is captured even with bypass
      wb_reg_write    = 1'b1;
      wb_rd           = 5'd1;
      tick();
      quiet();
      n_chk++;
      if (aux_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL pend_ready: got %0b want 0", aux_ready);
      end
      n_chk++;
      if (busy_mask !== 32'h20) begin
         n_fail++;
         $display("FAIL pend_busy: got %h want 00000020", busy_mask);
      end
      resetn = 1'b0;
      #1;
      n_chk++;
      if (busy_mask !== 32'h0 || rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst: busy %h we %0b want 0 0", busy_mask, rf_we);
      end
      tick();
      resetn = 1'b1;
      #1;
      n_chk++;
      if (aux_ready !== 1'b1 || rf_we !== 1'b0 || busy_mask !== 32'h0) begin
         n_fail++;
         $display("FAIL postrst: ready %0b we %0b busy %h want 1 0 0",
                  aux_ready, rf_we, busy_mask);
      end
   endtask

   task automatic test_idle_write();
      quiet();
      aux_issue_valid = 1'b1;
      aux_issue_rd    = 5'd3;
      #1;
      n_chk++;
      if (busy_mask !== 32'h0) begin
         n_fail++;
         $display("FAIL busy_early: got %h want 0", busy_mask);
      end
      tick();
      aux_issue_valid = 1'b0;
      aux_valid       = 1'b1;
      aux_rd          = 5'd3;
      aux_data        = 32'h1234;
      #1;
      n_chk++;
      if (busy_mask !== 32'h8 || aux_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL issue_busy: busy %h ready %0b want 00000008 1",
                  busy_mask, aux_ready);
      end
      n_chk++;
      if (rf_we !== BYP) begin
         n_fail++;
         $display("FAIL idle_we0: got %0b want %0b", rf_we, BYP);
      end
      tick();
      aux_valid = 1'b0;
      #1;
      n_chk++;
      if (rf_we !== !BYP) begin
         n_fail++;
         $display("FAIL idle_we1: got %0b want %0b", rf_we, !BYP);
      end
      if (!BYP) begin
         n_chk++;
         if (rf_rd !== 5'd3 || rf_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL idle_wr: rd %0d data %h want 3 00001234",
                     rf_rd, rf_data);
         end
      end
      n_chk++;
      if (busy_mask !== (BYP ? 32'h0 : 32'h8)) begin
         n_fail++;
         $display("FAIL idle_busy: got %h want %h",
                  busy_mask, BYP ? 32'h0 : 32'h8);
      end
      tick();
      n_chk++;
      if (busy_mask !== 32'h0 || rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_done: busy %h we %0b want 0 0",
                  busy_mask, rf_we);
      end
   endtask

   task automatic test_starvation();
      quiet();
      aux_issue_valid = 1'b1;
      aux_issue_rd    = 5'd7;
      tick();
      aux_issue_valid = 1'b0;
      aux_valid       = 1'b1;
      aux_rd          = 5'd7;
      aux_data        = 32'h77;
      wb_reg_write    = 1'b1;
      wb_rd           = 5'd9;
      wb_data         = 32'h99;
      #1;
      n_chk++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd9) begin
         n_fail++;
         $display("FAIL cap_wr: we %0b rd %0d want 1 9", rf_we, rf_rd);
      end
      tick();
      aux_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_chk++;
         if (rf_we !== 1'b1 || rf_rd !== 5'd9 || pipe_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL deny%0d: we %0b rd %0d stall %0b want 1 9 0",
                     i, rf_we, rf_rd, pipe_stall);
         end
         tick();
      end
      #1;
      n_chk++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'h77 ||
          pipe_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL force: we %0b rd %0d data %h stall %0b want 1 7 77 1",
                  rf_we, rf_rd, rf_data, pipe_stall);
      end
      tick();
      #1;
      n_chk++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd9 || pipe_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL after_force: we %0b rd %0d stall %0b want 1 9 0",
                  rf_we, rf_rd, pipe_stall);
      end
      n_chk++;
      if (busy_mask !== 32'h0 || aux_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL force_clr: busy %h ready %0b want 0 1",
                  busy_mask, aux_ready);
      end
      quiet();
      tick();
   endtask

   task automatic test_x0();
      quiet();
      wb_reg_write    = 1'b1;
      wb_rd           = 5'd0;
      wb_data         = 32'h5;
      aux_issue_valid = 1'b1;
      aux_issue_rd    = 5'd0;
      aux_valid       = 1'b1;
      aux_rd          = 5'd0;
      aux_data        = 32'hDEAD;
      #1;
      n_chk++;
      if (rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL x0_we: got %0b want 0", rf_we);
      end
      tick();
      quiet();
      #1;
      n_chk++;
      if (rf_we !== 1'b0 || aux_ready !== 1'b1 || busy_mask !== 32'h0) begin
         n_fail++;
         $display("FAIL x0_drop: we %0b ready %0b busy %h want 0 1 0",
                  rf_we, aux_ready, busy_mask);
      end
   endtask

   task automatic test_collision();
      quiet();
      aux_issue_valid = 1'b1;
      aux_issue_rd    = 5'd4;
      tick();
      aux_issue_valid = 1'b0;
      aux_valid       = 1'b1;
      aux_rd          = 5'd4;
      aux_data        = 32'h44;
      wb_reg_write    = 1'b1;
      wb_rd           = 5'd1;
      tick();
      quiet();
      aux_issue_valid = 1'b1;
      aux_issue_rd    = 5'd4;
      #1;
      n_chk++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_data !== 32'h44) begin
         n_fail++;
         $display("FAIL coll_wr: we %0b rd %0d data %h want 1 4 44",
                  rf_we, rf_rd, rf_data);
      end
      tick();
      aux_issue_valid = 1'b0;
      #1;
      n_chk++;
      if (busy_mask !== 32'h10) begin
         n_fail++;
         $display("FAIL coll_busy: got %h want 00000010", busy_mask);
      end
   endtask

   task automatic test_bypass();
      quiet();
      aux_issue_valid = 1'b1;
      aux_issue_rd    = 5'd6;
      tick();
      aux_issue_valid = 1'b0;
      aux_valid       = 1'b1;
      aux_rd          = 5'd6;
      aux_data        = 32'h55;
      #1;
      n_chk++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd6 || rf_data !== 32'h55 ||
          aux_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL byp_wr: we %0b rd %0d data %h ready %0b want 1 6 55 1",
                  rf_we, rf_rd, rf_data, aux_ready);
      end
      tick();
      aux_valid = 1'b0;
      #1;
      n_chk++;
      if (busy_mask[6] !== 1'b0 || aux_ready !== 1'b1 || rf_we !== 1'b0) begin
         n_fail++;
         $display("FAIL byp_after: busy6 %0b ready %0b we %0b want 0 1 0",
                  busy_mask[6], aux_ready, rf_we);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_idle_write();
      test_starvation();
      test_x0();
      test_collision();
      if (BYP)
         test_bypass();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
